siso_shift_reg: RTL and testbench



---
 rtl/siso_pkg.sv | 14 +
 rtl/siso_dff.sv | 19 +
 rtl/siso_shift_reg.sv | 63 ++++++
 tb/tb_siso_shift_reg.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// siso_pkg: shared constants and helpers for the SISO shift register.
//   SISO_DEPTH_DEFAULT : default chain depth
//   SISO_DEPTH_MAX     : largest supported chain depth
//   cnt_w(depth)       : width of a counter that must reach the value depth
package siso_pkg;

    localparam int SISO_DEPTH_DEFAULT = 4;
    localparam int SISO_DEPTH_MAX     = 64;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/siso_dff.sv
// siso_dff: single-bit D flip-flop with asynchronous active-high reset.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high, clears q to 0
//   d   : data input
//   q   : registered output
module siso_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

endmodule

// File: rtl/siso_shift_reg.sv
// siso_shift_reg: serial-in serial-out delay line of DEPTH flip-flops.
// A bit sampled on `in` appears on `out` DEPTH rising edges later.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high; clears all stages and the fill count
//   in   : serial data input
//   out  : serial data output (last stage)
//   full : high once DEPTH edges have occurred since reset
//   q    : [DEPTH-1:0] parallel view of the stages, q[0] newest
//          (present only when SISO_PAR_OUT_EN is defined)
// Parameters:
//   DEPTH : number of stages / latency in cycles, 1..64
// Configuration macro: SISO_PAR_OUT_EN
module siso_shift_reg
    import siso_pkg::*;
#(
    parameter int DEPTH = SISO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out,
`ifdef SISO_PAR_OUT_EN
    output logic [DEPTH-1:0] q,
`endif
    output logic             full
);

    localparam int CW = cnt_w(DEPTH);

    // chain[0] is the serial input, chain[i+1] is the output of stage i.
    // Keeping the input in the same vector avoids a special case for stage 0
    // and keeps DEPTH=1 legal.
    logic [DEPTH:0] chain;
    assign chain[0] = in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        siso_dff u_dff (
            .clk (clk),
            .rst (rst),
            .d   (chain[i]),
            .q   (chain[i+1])
        );
    end

    assign out = chain[DEPTH];

`ifdef SISO_PAR_OUT_EN
    assign q = chain[DEPTH:1];
`endif

    // Fill counter saturates at DEPTH; once there, every output bit is
    // real input data rather than reset filler.
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (cnt != CW'(DEPTH))   cnt <= cnt + 1'b1;
    end

    assign full = (cnt == CW'(DEPTH));

endmodule

// File: tb/tb_siso_shift_reg.sv
// tb_siso_shift_reg: randomized self-checking bench for siso_shift_reg.
// The reference model keeps the list of bits sampled since the last reset;
// out is the bit sampled DEPTH edges ago (0 if fewer), full means at least
// DEPTH samples exist.
module tb_siso_shift_reg;

    parameter int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic out;
    logic full;
`ifdef SISO_PAR_OUT_EN
    logic [DEPTH-1:0] q;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit hist[$];

    siso_shift_reg #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .out  (out),
`ifdef SISO_PAR_OUT_EN
        .q    (q),
`endif
        .full (full)
    );

    // first posedge at 10 ns, period 20 ns
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_out();
        int n = hist.size();
        return (n >= DEPTH) ? hist[n-DEPTH] : 1'b0;
    endfunction

    function automatic logic exp_full();
        return hist.size() >= DEPTH;
    endfunction

    function automatic logic [63:0] exp_q();
        logic [63:0] v = '0;
        int n = hist.size();
        for (int i = 0; i < DEPTH; i++)
            if (n > i) v[i] = hist[n-1-i];
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_out"},  64'(out),  64'(exp_out()));
        check({tag, "_full"}, 64'(full), 64'(exp_full()));
`ifdef SISO_PAR_OUT_EN
        check({tag, "_q"},    64'(q),    exp_q());
`endif
    endtask

    // one rising edge: model samples din, then check 2 ns later
    task automatic tick(input string tag);
        @(posedge clk);
        hist.push_back(din);
        #2;
        check_all(tag);
    endtask

    // async pulse between edges; caller sits at posedge+2
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        check("arst_out",  64'(out),  64'(0));
        check("arst_full", 64'(full), 64'(0));
`ifdef SISO_PAR_OUT_EN
        check("arst_q", 64'(q), 64'(0));
`endif
        #2 rst = 1'b0;
        hist.delete();
    endtask

    initial begin
        bit pat[7] = '{1, 0, 1, 1, 0, 0, 1};

        rst = 1'b1;
        din = 1'b1;
        #5 rst = 1'b0;
        #1;
        check("reset_out",  64'(out),  64'(0));
        check("reset_full", 64'(full), 64'(0));
`ifdef SISO_PAR_OUT_EN
        check("reset_q", 64'(q), 64'(0));
`endif

        // step fill: in held at 1
        for (int i = 1; i <= DEPTH + 2; i++) begin
            tick("fill");
            if (i == DEPTH - 1) check("fill_pre_out", 64'(out), 64'(0));
            if (i == DEPTH) begin
                check("fill_edge_out",  64'(out),  64'(1));
                check("fill_edge_full", 64'(full), 64'(1));
            end
        end

        // step drain: in drops to 0
        din = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) tick("drain");
        check("drain_out",  64'(out),  64'(0));
        check("drain_full", 64'(full), 64'(1));

        // fixed pattern
        for (int i = 0; i < 7; i++) begin
            din = pat[i];
            tick("pat");
        end
        din = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick("pat_tail");

        // directed mid-stream async reset with out=1
        din = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick("pre_arst");
        check("pre_arst_out", 64'(out), 64'(1));
        async_reset();
        for (int i = 0; i < DEPTH + 1; i++) tick("refill");

        // random stream with occasional async reset
        for (int i = 0; i < 400; i++) begin
            din = 1'($urandom);
            tick("rand");
            if ($urandom_range(0, 39) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
